l1_cache: RTL



---
 rtl/l1_cache.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 256-bit lines.
// Hits answer combinationally in IDLE; misses evict/refill over the pmem port.
module l1_cache #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic         mem_resp,
    output logic [31:0]  mem_rdata,
    output logic         hit,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int TAG_W = 27 - S_INDEX;
    localparam int LINES = 1 << S_INDEX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t state, state_next;

    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;
    logic [TAG_W-1:0]   tag_arr [LINES];
    logic [255:0]       data_arr [LINES];

    logic [TAG_W-1:0]   miss_tag;
    logic [S_INDEX-1:0] miss_index;
    logic               after_fill;

    logic [S_INDEX-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         req_word;
    logic               req;
    logic               req_match;
    logic               write_hit;
    logic               miss_start;
    logic               fill_done;
    logic               wb_done;
    logic               unused_addr_bits;

    assign req_index        = mem_address[4+S_INDEX:5];
    assign req_tag          = mem_address[31:5+S_INDEX];
    assign req_word         = mem_address[4:2];
    assign req              = mem_read | mem_write;
    assign req_match        = valid[req_index] && (tag_arr[req_index] == req_tag);
    assign fill_done        = (state == FILL) && pmem_resp;
    assign wb_done          = (state == WRITEBACK) && pmem_resp;
    assign unused_addr_bits = ^mem_address[1:0];

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        write_hit    = 1'b0;
        miss_start   = 1'b0;
        case (state)
            IDLE: begin
                // The live request is evaluated here, never the latched miss address.
                if (req) begin
                    if (req_match) begin
                        mem_resp  = 1'b1;
                        mem_rdata = data_arr[req_index][{req_word, 5'b00000} +: 32];
                        write_hit = mem_write;
                    end else begin
                        miss_start = 1'b1;
                        state_next = (valid[req_index] && dirty[req_index]) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[miss_index], miss_index, 5'b00000};
                pmem_wdata   = data_arr[miss_index];
                if (pmem_resp) state_next = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_index, 5'b00000};
                if (pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        hit = mem_resp & ~after_fill;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            after_fill <= 1'b0;
            miss_tag   <= '0;
            miss_index <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) after_fill <= 1'b0;
            if (miss_start) begin
                miss_tag   <= req_tag;
                miss_index <= req_index;
            end
            if (write_hit) dirty[req_index] <= 1'b1;
            if (wb_done) dirty[miss_index] <= 1'b0;
            // The first response after a refill is not counted as a hit.
            if (fill_done) begin
                valid[miss_index] <= 1'b1;
                dirty[miss_index] <= 1'b0;
                after_fill        <= 1'b1;
            end
        end
    end

    // Line storage is not reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (write_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_enable[b])
                    data_arr[req_index][{req_word, b[1:0], 3'b000} +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (fill_done) begin
            data_arr[miss_index] <= pmem_rdata;
            tag_arr[miss_index]  <= miss_tag;
        end
    end

endmodule
